// File: rtl/write_full_if.sv
// write_full_if: bundles the write-side FIFO pointer/flag signals.
//   slave  modport : used by write_full (consumes write_inc and read_ptr_sync,
//                    produces the address, Gray pointer and flags).
//   master modport : used by the writer / environment driving the block.
// Signals:
//   write_inc      write request, honoured only while full=0
//   read_ptr_sync  Gray read pointer already synchronised into the write clock
//   write_addr     RAM write address (low bits of the binary write pointer)
//   write_ptr      registered Gray write pointer for the read-domain synchroniser
//   full           registered full flag
//   almost_full    registered almost-full flag
//   write_level    registered occupancy seen from the write side, 0..DEPTH
//   overflow       sticky overflow flag (only when WRITE_OVERFLOW_EN is defined)
interface write_full_if #(
  parameter int ADDR_SIZE = 4
);
  logic                 write_inc;
  logic [ADDR_SIZE:0]   read_ptr_sync;
  logic [ADDR_SIZE-1:0] write_addr;
  logic [ADDR_SIZE:0]   write_ptr;
  logic                 full;
  logic                 almost_full;
  logic [ADDR_SIZE:0]   write_level;
`ifdef WRITE_OVERFLOW_EN
  logic                 overflow;
`endif

  modport slave (
`ifdef WRITE_OVERFLOW_EN
    output overflow,
`endif
    input  write_inc,
    input  read_ptr_sync,
    output write_addr,
    output write_ptr,
    output full,
    output almost_full,
    output write_level
  );

  modport master (
`ifdef WRITE_OVERFLOW_EN
    input  overflow,
`endif
    output write_inc,
    output read_ptr_sync,
    input  write_addr,
    input  write_ptr,
    input  full,
    input  almost_full,
    input  write_level
  );
endinterface

// File: rtl/write_full.sv
// write_full: write-domain pointer and flag logic of an asynchronous FIFO.
// Keeps the binary write pointer (its low bits address the RAM) and the Gray
// write pointer exported to the read domain, and compares against the
// synchronised Gray read pointer to produce registered full, almost_full and
// write_level.
// Ports:
//   write_clk    write-domain clock, all state updates on its rising edge
//   write_reset  synchronous active-high reset
//   bus          write_full_if.slave (see interface header for signal list)
// Optional feature: define WRITE_OVERFLOW_EN to add the sticky overflow flag,
// set by any write attempted while full. Without it such writes are dropped
// silently.
module write_full #(
  parameter int ADDR_SIZE    = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic           write_clk,
  input  logic           write_reset,
  write_full_if.slave    bus
);

  localparam int PW    = ADDR_SIZE + 1;
  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam logic [PW-1:0] AFULL_THRESH = PW'(DEPTH - AFULL_MARGIN);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic [PW-1:0] level_q, level_d;
  logic [PW-1:0] rbin;
  logic          accept;
  logic [PW-1:0] full_match;

  always_comb begin
    accept = bus.write_inc & ~full_q;
    bin_d  = bin_q + {{ADDR_SIZE{1'b0}}, accept};
    gray_d = bin2gray(bin_d);
    rbin   = gray2bin(bus.read_ptr_sync);
    // Full when the write pointer is exactly one lap ahead: in Gray code that
    // is the read pointer with its two MSBs inverted.
    full_match = {~bus.read_ptr_sync[PW-1:PW-2], bus.read_ptr_sync[PW-3:0]};
    full_d     = (gray_d == full_match);
    level_d    = bin_d - rbin;
    afull_d    = (level_d >= AFULL_THRESH);
  end

  always_ff @(posedge write_clk) begin
    if (write_reset) begin
      bin_q   <= '0;
      gray_q  <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
    end else begin
      bin_q   <= bin_d;
      gray_q  <= gray_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      level_q <= level_d;
    end
  end

`ifdef WRITE_OVERFLOW_EN
  logic overflow_q, overflow_d;

  always_comb begin
    overflow_d = overflow_q | (bus.write_inc & full_q);
  end

  always_ff @(posedge write_clk) begin
    if (write_reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign bus.overflow = overflow_q;
`endif

  assign bus.write_addr  = bin_q[ADDR_SIZE-1:0];
  assign bus.write_ptr   = gray_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.write_level = level_q;

endmodule

// File: tb/tb_write_full.sv
// tb_write_full: directed and randomized bench for write_full with
// ADDR_SIZE=4, AFULL_MARGIN=2. The reference keeps plain integer counts of
// writes and reads and derives every expected output from them.
module tb_write_full;

  localparam int AS = 4;

  logic clk;
  logic rst;

  write_full_if #(.ADDR_SIZE(AS)) bus ();

  write_full #(.ADDR_SIZE(AS), .AFULL_MARGIN(2)) dut (
    .write_clk   (clk),
    .write_reset (rst),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: number of accepted writes (mod 32) and expected flags.
  int w_cnt   = 0;
  int r_cnt   = 0;
  int e_level = 0;
  bit e_full  = 0;
  bit e_afull = 0;
  bit e_ovf   = 0;
  logic [4:0] prev_ptr = '0;

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, update the reference, compare.
  task automatic step(input bit rst_i, input bit inc_i, input int rb);
    rst               = rst_i;
    bus.write_inc     = inc_i;
    bus.read_ptr_sync = to_gray(rb);
    @(posedge clk);
    #1;
    if (rst_i) begin
      w_cnt = 0; e_level = 0; e_full = 0; e_afull = 0; e_ovf = 0;
    end else begin
      if (inc_i && e_full) e_ovf = 1;
      if (inc_i && !e_full) w_cnt = (w_cnt + 1) % 32;
      e_level = (w_cnt - rb + 64) % 32;
      e_full  = (e_level == 16);
      e_afull = (e_level >= 14);
      check("gray_one_bit", ($countones(prev_ptr ^ bus.write_ptr) <= 1), 1);
    end
    prev_ptr = bus.write_ptr;
    check("write_ptr",   bus.write_ptr,   to_gray(w_cnt));
    check("write_addr",  bus.write_addr,  w_cnt % 16);
    check("full",        bus.full,        e_full);
    check("almost_full", bus.almost_full, e_afull);
    check("write_level", bus.write_level, e_level);
`ifdef WRITE_OVERFLOW_EN
    check("overflow",    bus.overflow,    e_ovf);
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.write_inc = 1'b0;
    bus.read_ptr_sync = '0;

    // Reset with write_inc held high.
    step(1, 1, 0);
    step(1, 1, 0);
    check("reset_ptr", bus.write_ptr, 5'b00000);

    // Fill to full with the read side idle.
    for (int i = 1; i <= 16; i++) begin
      step(0, 1, 0);
      if (i == 14) begin
        check("fill14_level", bus.write_level, 14);
        check("fill14_afull", bus.almost_full, 1);
        check("fill14_full",  bus.full, 0);
      end
    end
    check("fill16_full", bus.full, 1);
    check("fill16_ptr",  bus.write_ptr, 5'b11000);
    check("fill16_addr", bus.write_addr, 0);

    // Writes while full are dropped.
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    check("wfull_ptr", bus.write_ptr, 5'b11000);
`ifdef WRITE_OVERFLOW_EN
    check("wfull_ovf", bus.overflow, 1);
`endif

    // Drain: read pointer moves to 1, then 3 (Gray 00010).
    step(0, 0, 1);
    check("drain1_level", bus.write_level, 15);
    check("drain1_full",  bus.full, 0);
    step(0, 0, 3);
    check("drain3_level", bus.write_level, 13);
    check("drain3_afull", bus.almost_full, 0);

    // Wrap: read pointer follows the write pointer one cycle behind.
    step(1, 0, 0);
    for (int i = 1; i <= 40; i++) begin
      step(0, 1, w_cnt);
      if (i == 32) check("wrap_ptr", bus.write_ptr, 5'b00000);
    end

    // Reset mid-fill.
    step(1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    check("mid_ptr", bus.write_ptr, 5'b00100);
    step(1, 1, 0);
    check("mid_rst_addr", bus.write_addr, 0);
    step(0, 1, 0);
    check("resume_addr", bus.write_addr, 1);

    // Randomized traffic with a legally lagging read pointer.
    r_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      int occ;
      bit do_rst;
      do_rst = ($urandom_range(59, 0) == 0);
      if (do_rst) begin
        r_cnt = 0;
        step(1, $urandom_range(1, 0), 0);
      end else begin
        occ = (w_cnt - r_cnt + 64) % 32;
        if ($urandom_range(2, 0) == 0) r_cnt = (r_cnt + $urandom_range(occ, 0)) % 32;
        step(0, ($urandom_range(3, 0) != 0), r_cnt);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
